add_chk: RTL and testbench

Registered self-checking monitor for the 4-bit registered adder: the consuming end of the adder's `a`/`b`/`sum` interface. Every clock it samples the operands the adder sees and computes the expected sum. `LATENCY` cycles later it compares that expected value against the adder's `sum` output. It keeps pass/fail counts and a sticky error flag, optionally halts on the first failure, and sits in the bench or on-chip BIST next to the adder.

---
 rtl/add_pkg.sv | 32 +++
 rtl/add_chk_if.sv | 14 +
 rtl/add_chk_pipe.sv | 41 ++++
 rtl/add_chk.sv | 221 ++++++++++++++++++++++
 tb/tb_add_chk.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// add_pkg: shared widths, FSM state and pipeline entry types for the 4-bit
// adder, its checker and the bench.
// Optional feature macro: ADD_CHK_CAPTURE_EN adds operand fields to each
// pipeline entry so the first failing transaction can be reported.
package add_pkg;

  localparam int OP_W  = 4;
  localparam int SUM_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } add_chk_state_e;

  typedef struct packed {
    logic             vld;
    logic [SUM_W-1:0] exp;
`ifdef ADD_CHK_CAPTURE_EN
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
`endif
  } add_chk_entry_t;

  // Full-width expected sum; the carry is kept so 15+15 yields 30.
  function automatic logic [SUM_W-1:0] exp_sum(input logic [OP_W-1:0] op_a,
                                               input logic [OP_W-1:0] op_b);
    return {1'b0, op_a} + {1'b0, op_b};
  endfunction

endpackage

// File: rtl/add_chk_if.sv
// add_chk_if: the adder's operand/result bus. The adder side drives it
// (master); the checker only observes it (slave).
interface add_chk_if;
  import add_pkg::*;

  logic             en;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic [SUM_W-1:0] sum;

  modport master (output en, a, b, sum);
  modport slave  (input  en, a, b, sum);

endinterface

// File: rtl/add_chk_pipe.sv
// add_chk_pipe: LATENCY-deep shift register of expectation entries.
// Stage 0 loads every edge; the last stage is what the comparator sees.
module add_chk_pipe
  import add_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  add_chk_entry_t din,
  output add_chk_entry_t dout,
  output logic           upstream_busy
);

  add_chk_entry_t stage_r [LATENCY];

  // Shift entries one stage per edge; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[LATENCY-1];

  // Any valid entry still upstream of the last stage keeps the pipe busy.
  always_comb begin
    upstream_busy = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      upstream_busy = upstream_busy | stage_r[i].vld;
    end
  end

endmodule

// File: rtl/add_chk.sv
// add_chk: registered self-checking monitor for the 4-bit registered adder.
// Samples a/b each enabled edge, compares the expected sum LATENCY edges
// later, keeps saturating pass/fail counts, a sticky err and optional halt.
// Optional feature macro: ADD_CHK_CAPTURE_EN adds fail_a/fail_b/fail_sum,
// holding the operands and received sum of the first mismatch.
module add_chk
  import add_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  add_chk_if.slave         bus,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             halted,
  output logic             chk_vld
`ifdef ADD_CHK_CAPTURE_EN
  ,
  output logic [OP_W-1:0]  fail_a,
  output logic [OP_W-1:0]  fail_b,
  output logic [SUM_W-1:0] fail_sum
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  add_chk_state_e   state_r;
  add_chk_state_e   state_nxt_s;
  add_chk_entry_t   entry_in_s;
  add_chk_entry_t   entry_last_s;
  logic             upstream_busy_s;
  logic             cmp_s;
  logic             match_s;
  logic             fail_s;
  logic [CNT_W-1:0] pass_cnt_r;
  logic [CNT_W-1:0] fail_cnt_r;
  logic [CNT_W-1:0] pass_cnt_nxt_s;
  logic [CNT_W-1:0] fail_cnt_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic             halted_r;
  logic             chk_vld_r;
  logic             chk_vld_nxt_s;
`ifdef ADD_CHK_CAPTURE_EN
  logic [OP_W-1:0]  fail_a_r;
  logic [OP_W-1:0]  fail_b_r;
  logic [SUM_W-1:0] fail_sum_r;
  logic [OP_W-1:0]  fail_a_nxt_s;
  logic [OP_W-1:0]  fail_b_nxt_s;
  logic [SUM_W-1:0] fail_sum_nxt_s;
`endif

  // Build the entry for this edge: valid flag, full-width expected sum, operands.
  always_comb begin
    entry_in_s     = '0;
    entry_in_s.vld = bus.en;
    entry_in_s.exp = exp_sum(bus.a, bus.b);
`ifdef ADD_CHK_CAPTURE_EN
    entry_in_s.a   = bus.a;
    entry_in_s.b   = bus.b;
`endif
  end

  add_chk_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (entry_in_s),
    .dout          (entry_last_s),
    .upstream_busy (upstream_busy_s)
  );

  // Equality test; an unknown sum falls into the else branch and fails.
  always_comb begin
    if (bus.sum == entry_last_s.exp) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  assign cmp_s  = entry_last_s.vld & (state_r != HALT);
  assign fail_s = cmp_s & ~match_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: prime, check, drain back to idle, or halt on failure.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.en) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL: begin
        if (entry_last_s.vld) begin
          if (fail_s && (STOP_ON_FAIL == 1'b1)) begin
            state_nxt_s = HALT;
          end else begin
            state_nxt_s = CHECK;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      CHECK: begin
        if (fail_s && (STOP_ON_FAIL == 1'b1)) begin
          state_nxt_s = HALT;
        end else if (!upstream_busy_s && !bus.en) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CHECK;
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output logic: compare pulse, saturating counters, sticky error, capture.
  always_comb begin
    pass_cnt_nxt_s = pass_cnt_r;
    fail_cnt_nxt_s = fail_cnt_r;
    err_nxt_s      = err_r;
    chk_vld_nxt_s  = 1'b0;
`ifdef ADD_CHK_CAPTURE_EN
    fail_a_nxt_s   = fail_a_r;
    fail_b_nxt_s   = fail_b_r;
    fail_sum_nxt_s = fail_sum_r;
`endif
    if (cmp_s) begin
      chk_vld_nxt_s = 1'b1;
      if (match_s) begin
        if (pass_cnt_r != CNT_MAX) begin
          pass_cnt_nxt_s = pass_cnt_r + CNT_ONE;
        end else begin
          pass_cnt_nxt_s = pass_cnt_r;
        end
      end else begin
        if (fail_cnt_r != CNT_MAX) begin
          fail_cnt_nxt_s = fail_cnt_r + CNT_ONE;
        end else begin
          fail_cnt_nxt_s = fail_cnt_r;
        end
        err_nxt_s = 1'b1;
`ifdef ADD_CHK_CAPTURE_EN
        if (!err_r) begin
          fail_a_nxt_s   = entry_last_s.a;
          fail_b_nxt_s   = entry_last_s.b;
          fail_sum_nxt_s = bus.sum;
        end else begin
          fail_a_nxt_s   = fail_a_r;
          fail_b_nxt_s   = fail_b_r;
          fail_sum_nxt_s = fail_sum_r;
        end
`endif
      end
    end else begin
      chk_vld_nxt_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_cnt_r <= '0;
      fail_cnt_r <= '0;
      err_r      <= 1'b0;
      halted_r   <= 1'b0;
      chk_vld_r  <= 1'b0;
`ifdef ADD_CHK_CAPTURE_EN
      fail_a_r   <= '0;
      fail_b_r   <= '0;
      fail_sum_r <= '0;
`endif
    end else begin
      pass_cnt_r <= pass_cnt_nxt_s;
      fail_cnt_r <= fail_cnt_nxt_s;
      err_r      <= err_nxt_s;
      halted_r   <= (state_nxt_s == HALT);
      chk_vld_r  <= chk_vld_nxt_s;
`ifdef ADD_CHK_CAPTURE_EN
      fail_a_r   <= fail_a_nxt_s;
      fail_b_r   <= fail_b_nxt_s;
      fail_sum_r <= fail_sum_nxt_s;
`endif
    end
  end

  assign pass_cnt = pass_cnt_r;
  assign fail_cnt = fail_cnt_r;
  assign err      = err_r;
  assign halted   = halted_r;
  assign chk_vld  = chk_vld_r;
`ifdef ADD_CHK_CAPTURE_EN
  assign fail_a   = fail_a_r;
  assign fail_b   = fail_b_r;
  assign fail_sum = fail_sum_r;
`endif

endmodule

// File: tb/tb_add_chk.sv
// tb_add_chk: three checker instances (LATENCY 1 / 3 / 1 with 2-bit
// counters and stop-on-fail) driven by emulated adders, compared every
// cycle against a queue-based expectation model, plus literal pin checks.
// Optional feature macro: ADD_CHK_CAPTURE_EN (capture ports are checked too).
`timescale 1ns/1ps
module tb_add_chk;
  import add_pkg::*;

  localparam int ND = 3;
  localparam int LAT  [ND] = '{1, 3, 1};
  localparam int MAXC [ND] = '{65535, 65535, 3};
  localparam int STOP [ND] = '{0, 0, 1};

  typedef struct {
    bit vld;
    int exp;
    int a;
    int b;
  } mentry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_chk_if if0 ();
  add_chk_if if1 ();
  add_chk_if if2 ();

  logic [15:0] pc0, fc0, pc1, fc1;
  logic [1:0]  pc2, fc2;
  logic        er0, er1, er2, hl0, hl1, hl2, cv0, cv1, cv2;
`ifdef ADD_CHK_CAPTURE_EN
  logic [3:0]  fa0, fa1, fa2, fb0, fb1, fb2;
  logic [4:0]  fs0, fs1, fs2;
`endif

  add_chk #(.LATENCY(1), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .pass_cnt(pc0), .fail_cnt(fc0),
    .err(er0), .halted(hl0), .chk_vld(cv0)
`ifdef ADD_CHK_CAPTURE_EN
    , .fail_a(fa0), .fail_b(fb0), .fail_sum(fs0)
`endif
  );
  add_chk #(.LATENCY(3), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .pass_cnt(pc1), .fail_cnt(fc1),
    .err(er1), .halted(hl1), .chk_vld(cv1)
`ifdef ADD_CHK_CAPTURE_EN
    , .fail_a(fa1), .fail_b(fb1), .fail_sum(fs1)
`endif
  );
  add_chk #(.LATENCY(1), .CNT_W(2), .STOP_ON_FAIL(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .pass_cnt(pc2), .fail_cnt(fc2),
    .err(er2), .halted(hl2), .chk_vld(cv2)
`ifdef ADD_CHK_CAPTURE_EN
    , .fail_a(fa2), .fail_b(fb2), .fail_sum(fs2)
`endif
  );

  // Stimulus shared by all instances; each gets its own sum.
  logic       en_d;
  logic [3:0] a_d, b_d;
  logic [4:0] sum_d [ND];

  // Model state.
  mentry_t mq [ND][$];
  mentry_t mh, mn;
  int m_pass [ND], m_fail [ND], m_fa [ND], m_fb [ND], m_fs [ND];
  bit m_err [ND], m_halt [ND], m_chk [ND];
  int cyc = 0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Expectation model: each sampled operand pair waits LAT edges, then is
  // judged against the sum presented on that edge.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < ND; i++) begin
      if (!rst_n) begin
        m_pass[i] = 0; m_fail[i] = 0; m_err[i] = 0; m_halt[i] = 0; m_chk[i] = 0;
        m_fa[i] = 0; m_fb[i] = 0; m_fs[i] = 0;
        mq[i].delete();
        for (int k = 0; k < LAT[i]; k++) mq[i].push_back('{0, 0, 0, 0});
      end else begin
        mh = mq[i].pop_front();
        m_chk[i] = 0;
        if (mh.vld && !m_halt[i]) begin
          m_chk[i] = 1;
          if (int'(sum_d[i]) == mh.exp) begin
            if (m_pass[i] < MAXC[i]) m_pass[i]++;
          end else begin
            if (m_fail[i] < MAXC[i]) m_fail[i]++;
            if (!m_err[i]) begin
              m_fa[i] = mh.a; m_fb[i] = mh.b; m_fs[i] = int'(sum_d[i]);
            end
            m_err[i] = 1;
            if (STOP[i] != 0) m_halt[i] = 1;
          end
        end
        mn.vld = en_d; mn.exp = int'(a_d) + int'(b_d); mn.a = int'(a_d); mn.b = int'(b_d);
        mq[i].push_back(mn);
      end
    end
  end

  task automatic cmp_dut(input int i, input int pc, input int fc, input int er,
                         input int hl, input int cv);
    check($sformatf("pass_cnt[%0d]", i), pc, m_pass[i]);
    check($sformatf("fail_cnt[%0d]", i), fc, m_fail[i]);
    check($sformatf("err[%0d]", i), er, int'(m_err[i]));
    check($sformatf("halted[%0d]", i), hl, int'(m_halt[i]));
    check($sformatf("chk_vld[%0d]", i), cv, int'(m_chk[i]));
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      cmp_dut(0, int'(pc0), int'(fc0), int'(er0), int'(hl0), int'(cv0));
      cmp_dut(1, int'(pc1), int'(fc1), int'(er1), int'(hl1), int'(cv1));
      cmp_dut(2, int'(pc2), int'(fc2), int'(er2), int'(hl2), int'(cv2));
`ifdef ADD_CHK_CAPTURE_EN
      check("fail_a[0]", int'(fa0), m_fa[0]); check("fail_b[0]", int'(fb0), m_fb[0]);
      check("fail_sum[0]", int'(fs0), m_fs[0]);
      check("fail_a[1]", int'(fa1), m_fa[1]); check("fail_b[1]", int'(fb1), m_fb[1]);
      check("fail_sum[1]", int'(fs1), m_fs[1]);
      check("fail_a[2]", int'(fa2), m_fa[2]); check("fail_b[2]", int'(fb2), m_fb[2]);
      check("fail_sum[2]", int'(fs2), m_fs[2]);
`endif
    end
  end

  // One clock: drive at the falling edge, return 1 ns after the rising edge.
  // fmask selects instances whose adder misbehaves; fval<0 means random corruption.
  task automatic step(input logic rst, input logic en, input int a, input int b,
                      input bit [2:0] fmask, input int fval);
    int hv;
    @(negedge clk);
    rst_n = rst;
    en_d  = en;
    a_d   = 4'(a);
    b_d   = 4'(b);
    for (int i = 0; i < ND; i++) begin
      if (mq[i].size() > 0 && mq[i][0].vld) hv = mq[i][0].exp;
      else hv = int'($urandom_range(31, 0));
      if (fmask[i]) begin
        if (fval >= 0) hv = fval;
        else hv = hv ^ int'($urandom_range(31, 1));
      end
      sum_d[i] = 5'(hv);
    end
    if0.en = en_d; if0.a = a_d; if0.b = b_d; if0.sum = sum_d[0];
    if1.en = en_d; if1.a = a_d; if1.b = b_d; if1.sum = sum_d[1];
    if2.en = en_d; if2.a = a_d; if2.b = b_d; if2.sum = sum_d[2];
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k0, npulse, p0, p1, hcnt;
    bit rr, ee;
    bit [2:0] fm;
    en_d = 1'b0; a_d = 4'd0; b_d = 4'd0;
    for (int i = 0; i < ND; i++) sum_d[i] = 5'd0;

    // Reset for two edges.
    step(1'b0, 1'b0, 0, 0, 3'b000, 0);
    step(1'b0, 1'b0, 0, 0, 3'b000, 0);
    check("rst pass_cnt", int'(pc0), 0);
    check("rst err", int'(er0), 0);
    check("rst halted", int'(hl2), 0);

    // Correct adder: 4+3 x3, 5+3, 5+2.
    step(1'b1, 1'b1, 4, 3, 3'b000, 0);
    check("first edge no chk_vld", int'(cv0), 0);
    step(1'b1, 1'b1, 4, 3, 3'b000, 0);
    check("second edge chk_vld", int'(cv0), 1);
    step(1'b1, 1'b1, 4, 3, 3'b000, 0);
    step(1'b1, 1'b1, 5, 3, 3'b000, 0);
    step(1'b1, 1'b1, 5, 2, 3'b000, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0, 3'b000, 0);
    check("directed pass L1", int'(pc0), 5);
    check("directed fail L1", int'(fc0), 0);
    check("directed pass L3", int'(pc1), 5);
    check("saturated pass W2", int'(pc2), 3);

    // Full range: 15+15=30 accepted; instance 0 sees a truncated 14.
    step(1'b1, 1'b1, 15, 15, 3'b000, 0);
    step(1'b1, 1'b0, 0, 0, 3'b001, 14);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 3'b000, 0);
    check("truncated sum fail_cnt", int'(fc0), 1);
    check("truncated sum err", int'(er0), 1);
    check("30 accepted L3", int'(pc1), 6);

    // Injected fault with stop-on-fail: sum 6 for 4+3.
    step(1'b1, 1'b1, 4, 3, 3'b000, 0);
    step(1'b1, 1'b1, 4, 3, 3'b100, 6);
    check("halt fail_cnt", int'(fc2), 1);
    check("halted", int'(hl2), 1);
    hcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i < 2) ? 1'b1 : 1'b0, 4, 3, 3'b100, -1);
      hcnt += int'(cv2);
    end
    check("no chk_vld after halt", hcnt, 0);
    check("fail_cnt held in halt", int'(fc2), 1);
`ifdef ADD_CHK_CAPTURE_EN
    check("capture fail_a", int'(fa2), 4);
    check("capture fail_b", int'(fb2), 3);
    check("capture fail_sum", int'(fs2), 6);
`endif

    // Reset with two entries in flight in the LATENCY=3 instance.
    step(1'b1, 1'b1, 1, 2, 3'b000, 0);
    step(1'b1, 1'b1, 2, 2, 3'b000, 0);
    step(1'b0, 1'b0, 0, 0, 3'b000, 0);
    hcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 0, 0, 3'b000, 0);
      hcnt += int'(cv1);
    end
    check("no compares after reset", hcnt, 0);
    check("halt cleared by reset", int'(hl2), 0);

    // Bubble with LATENCY=3: en 1,0,1 -> pulses at k+3 and k+5.
    step(1'b1, 1'b1, 3, 4, 3'b000, 0);
    k0 = cyc; npulse = 0; p0 = -1; p1 = -1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, (i == 1) ? 1'b1 : 1'b0, 6, 7, 3'b000, 0);
      if (cv1) begin
        if (npulse == 0) p0 = cyc - k0;
        else p1 = cyc - k0;
        npulse++;
      end
    end
    check("bubble pulse count", npulse, 2);
    check("bubble first pulse", p0, 3);
    check("bubble second pulse", p1, 5);

    // Randomized traffic with occasional faults and resets.
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(99, 0) != 0);
      ee = ($urandom_range(3, 0) != 0);
      fm[0] = ($urandom_range(19, 0) == 0);
      fm[1] = ($urandom_range(19, 0) == 0);
      fm[2] = ($urandom_range(99, 0) == 0);
      step(rr, ee, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), fm, -1);
    end
    step(1'b1, 1'b0, 0, 0, 3'b000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
